// File: rtl/pwm_soft_start.sv
// Soft-start controller for a downstream PWM stage.
// A start request latches a target duty, a period, a ramp step and a tick
// divider, then walks the duty toward the target one step per tick. A stop
// request walks the duty down to zero and then drops the counter enable.
// A done pulse marks the end of every ramp, whether up, retarget or down.
module pwm_soft_start #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic [7:0]       target_duty,
   input  logic [7:0]       target_period,
   input  logic [7:0]       step,
   input  logic [DIV_W-1:0] tick_div,
   output logic [7:0]       period,
   output logic [7:0]       duty,
   output logic             enable,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP      = 2'd1,
      HOLD      = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   state_t           state, state_next;
   logic [7:0]       tgt, tgt_next;
   logic [7:0]       stp, stp_next;
   logic [DIV_W-1:0] div, div_next;
   logic [DIV_W-1:0] cnt, cnt_next;
   logic [7:0]       duty_next;
   logic [7:0]       period_next;
   logic             enable_next;
   logic             done_next;

   // Values captured on an accepted start. The target can never exceed the
   // period, and a zero step or zero divider behaves as one so the ramp
   // always makes progress.
   logic [7:0]       samp_tgt;
   logic [7:0]       samp_stp;
   logic [DIV_W-1:0] samp_div;

   assign samp_tgt = (target_duty < target_period) ? target_duty : target_period;
   assign samp_stp = (step == 8'd0) ? 8'd1 : step;
   assign samp_div = (tick_div == '0) ? DIV_W'(1) : tick_div;

   // Candidate duty values for one tick. The upward sum is carried in nine
   // bits so a large step near the top of the range clamps instead of wrapping.
   logic [8:0] up_sum;
   logic [8:0] dn_floor;
   logic [7:0] up_val;
   logic [7:0] dn_val;
   logic [7:0] zero_val;
   logic       tick;

   assign up_sum   = {1'b0, duty} + {1'b0, stp};
   assign up_val   = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[7:0];
   assign dn_floor = {1'b0, tgt} + {1'b0, stp};
   assign dn_val   = ({1'b0, duty} >= dn_floor) ? (duty - stp) : tgt;
   assign zero_val = (duty > stp) ? (duty - stp) : 8'd0;
   assign tick     = (cnt == (div - DIV_W'(1)));

   assign busy = (state == RAMP) || (state == RAMP_DOWN);

   // Next-state and datapath decisions; stop outranks start everywhere.
   always_comb begin
      state_next  = state;
      tgt_next    = tgt;
      stp_next    = stp;
      div_next    = div;
      cnt_next    = cnt;
      duty_next   = duty;
      period_next = period;
      enable_next = enable;
      done_next   = 1'b0;

      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_next  = RAMP;
               tgt_next    = samp_tgt;
               stp_next    = samp_stp;
               div_next    = samp_div;
               cnt_next    = '0;
               period_next = target_period;
               enable_next = 1'b1;
            end
         end

         RAMP: begin
            if (stop) begin
               state_next = RAMP_DOWN;
               cnt_next   = '0;
            end else if (start) begin
               tgt_next    = samp_tgt;
               stp_next    = samp_stp;
               div_next    = samp_div;
               cnt_next    = '0;
               period_next = target_period;
            end else if (duty == tgt) begin
               state_next = HOLD;
               done_next  = 1'b1;
               cnt_next   = '0;
            end else if (tick) begin
               duty_next = (duty < tgt) ? up_val : dn_val;
               cnt_next  = '0;
            end else begin
               cnt_next = cnt + DIV_W'(1);
            end
         end

         HOLD: begin
            if (stop) begin
               state_next = RAMP_DOWN;
               cnt_next   = '0;
            end else if (start) begin
               state_next  = RAMP;
               tgt_next    = samp_tgt;
               stp_next    = samp_stp;
               div_next    = samp_div;
               cnt_next    = '0;
               period_next = target_period;
            end
         end

         RAMP_DOWN: begin
            if (duty == 8'd0) begin
               state_next  = IDLE;
               enable_next = 1'b0;
               done_next   = 1'b1;
               cnt_next    = '0;
            end else if (tick) begin
               duty_next = zero_val;
               cnt_next  = '0;
            end else begin
               cnt_next = cnt + DIV_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything with no done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         tgt    <= 8'd0;
         stp    <= 8'd0;
         div    <= '0;
         cnt    <= '0;
         duty   <= 8'd0;
         period <= 8'd0;
         enable <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         tgt    <= tgt_next;
         stp    <= stp_next;
         div    <= div_next;
         cnt    <= cnt_next;
         duty   <= duty_next;
         period <= period_next;
         enable <= enable_next;
         done   <= done_next;
      end
   end

endmodule
